// File: rtl/div_seq_responder_pkg.sv
// Shared definitions for the sequential signed divider: FSM encodings and default width.
package div_seq_responder_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_seq_responder_abs_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module div_seq_responder_abs_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y_c
);

    always_comb begin
        y_c = neg ? (~a + WIDTH'(1)) : a;
    end

endmodule

// File: rtl/div_seq_responder.sv
// Sequential signed restoring divider answering the control unit's start/done handshake.
module div_seq_responder
    import div_seq_responder_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] dvd_abs, dvs_abs, quo_fix, rem_fix;
    logic [WIDTH:0]   trial;

    div_seq_responder_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
        .a(dividend), .neg(dividend[WIDTH-1]), .y_c(dvd_abs)
    );
    div_seq_responder_abs_neg #(.WIDTH(WIDTH)) u_abs_dvs (
        .a(divisor), .neg(divisor[WIDTH-1]), .y_c(dvs_abs)
    );
    div_seq_responder_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .a(quo_q), .neg(sgn_quo_q), .y_c(quo_fix)
    );
    div_seq_responder_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .a(rem_q), .neg(sgn_rem_q), .y_c(rem_fix)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= DIV_IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            sgn_quo_q  <= 1'b0;
            sgn_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            sgn_quo_q  <= sgn_quo_d;
            sgn_rem_q  <= sgn_rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        sgn_quo_d  = sgn_quo_q;
        sgn_rem_d  = sgn_rem_q;
        busy_d     = busy_q;
        done_d     = done_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        // rem stays below dvs <= 2^(W-1), so its MSB is always clear before the shift
        trial = {1'b0, rem_q[WIDTH-2:0], quo_q[WIDTH-1]} - {1'b0, dvs_q};

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    div_zero_d = 1'b0;
                    quo_d      = dvd_abs;
                    dvs_d      = dvs_abs;
                    sgn_quo_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sgn_rem_d  = dividend[WIDTH-1];
                    rem_d      = '0;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    if (divisor == '0) begin
                        // Zero divisor skips the iterations; FIX raises done without touching results
                        div_zero_d = 1'b1;
                        state_d    = DIV_FIX;
                    end else begin
                        state_d    = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                if (!div_zero_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
                done_d  = 1'b1;
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_div_seq_responder.sv
// Directed bench for div_seq_responder with a result scoreboard and latency checks.
module tb_div_seq_responder;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t        sb[$];
    logic [31:0] model_lo = '0;
    logic [31:0] model_hi = '0;

    always #5 clk = ~clk;

    div_seq_responder #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Truncating signed division model in 64 bits; zero divisor keeps previous results
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb_, q, r;
        if (b == 32'd0) begin
            e.lo = model_lo;
            e.hi = model_hi;
            e.dz = 1'b1;
        end else begin
            sa   = {{32{a[31]}}, a};
            sb_  = {{32{b[31]}}, b};
            q    = sa / sb_;
            r    = sa % sb_;
            e.lo = q[31:0];
            e.hi = r[31:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Start one divide, optionally pulse a second start mid-run, then check latency and results
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input int pulse_at);
        exp_t e;
        int   lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e = model(a, b);
        model_lo = e.lo;
        model_hi = e.hi;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            start = (lat == pulse_at);
            if (start) begin
                dividend = 32'd50;
                divisor  = 32'd5;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_lo"}, lo_out, e.lo);
            check({tag, "_hi"}, hi_out, e.hi);
            check({tag, "_dz"}, 32'(div_zero), 32'(e.dz));
        end
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check({tag, "_no_done"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_div("div100_7", 32'd100, 32'd7, 33, -1);
        run_div("div5_0", 32'd5, 32'd0, 1, -1);
        run_div("divm7_2", 32'hFFFF_FFF9, 32'd2, 33, -1);
        run_div("div7_m2", 32'd7, 32'hFFFF_FFFE, 33, -1);
        run_div("divmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 33, -1);
        run_div("divm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, -1);

        // Reset in the middle of a divide discards it
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_dz", 32'(div_zero), 32'd0);
        check("midrst_hi", hi_out, 32'd0);
        check("midrst_lo", lo_out, 32'd0);
        model_lo = '0;
        model_hi = '0;
        @(negedge clk);
        reset = 1'b1;
        quiet("midrst", 40);
        run_div("div9_3", 32'd9, 32'd3, 33, -1);

        // Start pulsed while busy is ignored
        run_div("ignore_start", 32'd100, 32'd7, 33, 5);
        quiet("ignore_start", 40);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
